// File: rtl/mul_hash_sched_pkg.sv
// rtl/mul_hash_sched_pkg.sv - shared constants, FSM states and round-robin pick helper
package mul_hash_sched_pkg;

  localparam logic [63:0] HASH_CONST = 64'h0b4e0ef37bc32127;
  localparam int          MAX_REQ    = 16;

  typedef enum logic [1:0] {RUN, DRAIN, IDLE} sched_state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping modulo n (n <= MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [3:0]         ptr,
                                       input int                 n);
    rr_pick_t r;
    int       j;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        j = int'(ptr) + i;
        if (j >= n) j = j - n;
        if (!r.found && valid[j]) begin
          r.found = 1'b1;
          r.idx   = 4'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_hash.sv
// rtl/mul_hash.sv - pipelined byte x HASH_CONST multiplier, four 24-bit partial products
// Latency 2 + DSP_LAT: input register, DSP_LAT multiplier stages, output register.
module mul_hash
  import mul_hash_sched_pkg::*;
#(
  parameter int DSP_LAT = 3
) (
  input  logic        clk,
  input  logic [7:0]  a,
  output logic [23:0] ab0,
  output logic [23:0] ab1,
  output logic [23:0] ab2,
  output logic [23:0] ab3
);

  logic [7:0]  a_q;
  logic [23:0] dsp [DSP_LAT][4];

  // Data path carries no reset; validity is tracked by the caller's tag pipe.
  always_ff @(posedge clk) begin
    a_q <= a;
    for (int k = 0; k < 4; k++) begin
      dsp[0][k] <= 24'(a_q) * 24'(HASH_CONST[16*k +: 16]);
    end
    for (int s = 1; s < DSP_LAT; s++) begin
      for (int k = 0; k < 4; k++) begin
        dsp[s][k] <= dsp[s-1][k];
      end
    end
    ab0 <= dsp[DSP_LAT-1][0];
    ab1 <= dsp[DSP_LAT-1][1];
    ab2 <= dsp[DSP_LAT-1][2];
    ab3 <= dsp[DSP_LAT-1][3];
  end

endmodule

// File: rtl/mul_hash_sched_fifo.sv
// rtl/mul_hash_sched_fifo.sv - show-ahead synchronous FIFO with occupancy count
module mul_hash_sched_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_valid = (count != '0);
  assign pop      = rd_valid & rd_ready;
  // Zero while empty so the output holds its reset value between results.
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_valid) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)      rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(wr_valid) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_valid) mem[wr_ptr] <= wr_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_valid && (count == CNT_W'(DEPTH)) && !pop));

endmodule

// File: rtl/mul_hash_sched.sv
// rtl/mul_hash_sched.sv - round-robin sharing of mul_hash across byte requesters
// Optional MUL_HASH_SCHED_STATS_EN adds per-requester grant and credit-stall counters.
module mul_hash_sched
  import mul_hash_sched_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DSP_LAT    = 3,
  parameter  int HASH_W     = 32,
  parameter  int FIFO_DEPTH = 8,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int PIPE_LAT   = DSP_LAT + 3,
  localparam int CRED_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [HASH_W-1:0]    out_hash,
  output logic [ID_W-1:0]      out_id,
  input  logic                 flush,
  output logic                 flush_done
`ifdef MUL_HASH_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0] stat_grants,
  output logic [31:0]           stat_stall_cycles
`endif
);

  if (FIFO_DEPTH < DSP_LAT + 4) begin : g_depth_check
    $error("mul_hash_sched: FIFO_DEPTH must be at least DSP_LAT + 4");
  end
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_req_check
    $error("mul_hash_sched: NUM_REQ must be in 2..16");
  end

  sched_state_t              state;
  logic [ID_W-1:0]           rr_ptr;
  logic [CRED_W-1:0]         credits;
  logic [PIPE_LAT-2:0]       tag_v;
  logic [PIPE_LAT-2:0][ID_W-1:0] tag_id;
  rr_pick_t                  pick;
  logic                      grant;
  logic [ID_W-1:0]           grant_id;
  logic [7:0]                mh_a;
  logic [23:0]               ab0, ab1, ab2, ab3;
  logic                      pop;
  logic [CRED_W-1:0]         fifo_count;
  logic [HASH_W+ID_W-1:0]    fifo_wdata;
  logic [HASH_W+ID_W-1:0]    fifo_rdata;

  // Grant is gated by rst so req_ready reads zero throughout reset.
  always_comb begin
    pick      = rr_pick(16'(req_valid), 4'(rr_ptr), NUM_REQ);
    grant     = !rst && (state == RUN) && !flush && (credits != '0) && pick.found;
    grant_id  = ID_W'(pick.idx);
    req_ready = '0;
    mh_a      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (pick.idx == 4'(i));
      mh_a         = mh_a | (req_data[8*i +: 8] & {8{req_ready[i]}});
    end
  end

  assign pop = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      credits <= CRED_W'(FIFO_DEPTH);
      tag_v   <= '0;
      tag_id  <= '0;
    end else begin
      if (grant) begin
        rr_ptr <= (int'(pick.idx) == NUM_REQ - 1) ? '0 : ID_W'(grant_id + 1'b1);
      end
      if (grant && !pop)      credits <= credits - 1'b1;
      else if (!grant && pop) credits <= credits + 1'b1;
      tag_v  <= {tag_v[PIPE_LAT-3:0], grant};
      tag_id <= {tag_id[PIPE_LAT-3:0], grant_id};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (flush) state <= DRAIN;
        end
        DRAIN: begin
          if (!flush) begin
            state <= RUN;
          end else if (tag_v == '0 && fifo_count == '0) begin
            state      <= IDLE;
            flush_done <= 1'b1;
          end
        end
        IDLE: begin
          if (!flush) begin
            state      <= RUN;
            flush_done <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

  mul_hash #(
    .DSP_LAT (DSP_LAT)
  ) u_mul_hash (
    .clk (clk),
    .a   (mh_a),
    .ab0 (ab0),
    .ab1 (ab1),
    .ab2 (ab2),
    .ab3 (ab3)
  );

  // The FIFO write is the combine register: partial products summed into the entry.
  assign fifo_wdata = {tag_id[PIPE_LAT-2],
                       HASH_W'(64'(ab0) + (64'(ab1) << 16) + (64'(ab2) << 32) + (64'(ab3) << 48))};

  mul_hash_sched_fifo #(
    .WIDTH (HASH_W + ID_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (tag_v[PIPE_LAT-2]),
    .wr_data  (fifo_wdata),
    .rd_ready (out_ready),
    .rd_valid (out_valid),
    .rd_data  (fifo_rdata),
    .count    (fifo_count)
  );

  assign out_hash = fifo_rdata[HASH_W-1:0];
  assign out_id   = fifo_rdata[HASH_W +: ID_W];

`ifdef MUL_HASH_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && stat_grants[32*i +: 32] != '1) begin
          stat_grants[32*i +: 32] <= stat_grants[32*i +: 32] + 1'b1;
        end
      end
      if (|req_valid && credits == '0 && stat_stall_cycles != '1) begin
        stat_stall_cycles <= stat_stall_cycles + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mul_hash_sched.sv
// tb/tb_mul_hash_sched.sv - directed bench with behavioural scoreboard for mul_hash_sched
module tb_mul_hash_sched;

  localparam int          NUM_REQ    = 4;
  localparam int          DSP_LAT    = 3;
  localparam int          HASH_W     = 64;
  localparam int          FIFO_DEPTH = 8;
  localparam int          ID_W       = 2;
  localparam int          PIPE_LAT   = DSP_LAT + 3;
  localparam logic [63:0] K          = 64'h0b4e0ef37bc32127;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ*8-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [HASH_W-1:0]    out_hash;
  logic [ID_W-1:0]      out_id;
  logic                 flush = 1'b0;
  logic                 flush_done;

  always #5 clk = ~clk;

  mul_hash_sched #(
    .NUM_REQ    (NUM_REQ),
    .DSP_LAT    (DSP_LAT),
    .HASH_W     (HASH_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_hash   (out_hash),
    .out_id     (out_id),
    .flush      (flush),
    .flush_done (flush_done)
  );

  typedef struct {
    int          t;
    int          id;
    logic [63:0] h;
  } item_t;
  typedef enum {M_RUN, M_DRAIN, M_IDLE} mstate_t;

  item_t       q[$];
  int          glog[$];
  mstate_t     mstate = M_RUN;
  int          total = 0, bad = 0, cyc = 0, ptr = 0;
  int          grant_cnt = 0, pop_cnt = 0, ov_cnt = 0;
  int          last_grant_cyc = 0, last_out_cyc = 0;
  logic [63:0] last_out_hash = '0;
  int          last_out_id = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every granted byte must return (byte*K mod 2^64) with its id,
  // PIPE_LAT cycles after grant, in grant order.
  task automatic cycle_check();
    logic [NUM_REQ-1:0] exp_ready;
    logic               exp_ov, found, pre_empty;
    int                 g;
    item_t              it;
    cyc++;
    if (out_valid) ov_cnt++;
    if (rst) begin
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_hash", out_hash, 64'(0));
      chk("rst_out_id", 64'(out_id), 64'(0));
      chk("rst_flush_done", 64'(flush_done), 64'(0));
      q.delete();
      ptr    = 0;
      mstate = M_RUN;
      return;
    end
    exp_ready = '0;
    found     = 1'b0;
    g         = 0;
    if (mstate == M_RUN && !flush && q.size() < FIFO_DEPTH) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        int j;
        j = (ptr + i) % NUM_REQ;
        if (!found && req_valid[j]) begin
          found = 1'b1;
          g     = j;
        end
      end
      if (found) exp_ready[g] = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    exp_ov = (q.size() > 0) && (q[0].t + PIPE_LAT <= cyc);
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov) begin
      chk("out_hash", out_hash, q[0].h);
      chk("out_id", 64'(out_id), 64'(q[0].id));
    end
    chk("flush_done", 64'(flush_done), 64'(mstate == M_IDLE));
    if (out_valid && out_ready) begin
      pop_cnt++;
      last_out_cyc  = cyc;
      last_out_hash = out_hash;
      last_out_id   = int'(out_id);
    end
    pre_empty = (q.size() == 0);
    if (exp_ov && out_ready) void'(q.pop_front());
    if (found) begin
      it.t = cyc;
      it.id = g;
      it.h = 64'(req_data[8*g +: 8]) * K;
      q.push_back(it);
      ptr = (g + 1) % NUM_REQ;
      grant_cnt++;
      glog.push_back(g);
      last_grant_cyc = cyc;
    end
    case (mstate)
      M_RUN:   if (flush) mstate = M_DRAIN;
      M_DRAIN: if (!flush) mstate = M_RUN; else if (pre_empty) mstate = M_IDLE;
      default: if (!flush) mstate = M_RUN;
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic all_valid_data(input int seed);
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) req_data[8*i +: 8] = 8'(seed * 7 + i * 61 + 3);
  endtask

  initial begin
    int gsnap, psnap, osnap;
    int exp_ord[8];
    exp_ord = '{3, 0, 1, 2, 3, 0, 1, 2};

    ticks(2);
    rst = 1'b0;

    // 1: requester 0 sends 0x01
    req_valid = 4'b0001;
    req_data  = 32'h0000_0001;
    tick();
    req_valid = '0;
    ticks(10);
    chk("t1_hash64", last_out_hash, 64'h0b4e0ef37bc32127);
    chk("t1_hash32", 64'(last_out_hash[31:0]), 64'h7bc32127);
    chk("t1_id", 64'(last_out_id), 64'(0));
    chk("t1_latency", 64'(last_out_cyc - last_grant_cyc), 64'(6));

    // 2: requester 2 sends 0x02
    req_valid = 4'b0100;
    req_data  = 32'h0002_0000;
    tick();
    req_valid = '0;
    ticks(10);
    chk("t2_hash", last_out_hash, 64'h169c1de6f786424e);
    chk("t2_id", 64'(last_out_id), 64'(2));

    // 3: all requesters continuously valid
    gsnap = grant_cnt;
    for (int c = 0; c < 12; c++) begin
      all_valid_data(c);
      tick();
    end
    req_valid = '0;
    chk("t3_throughput", 64'(grant_cnt - gsnap), 64'(12));
    for (int k = 0; k < 8; k++) chk("t3_order", 64'(glog[gsnap + k]), 64'(exp_ord[k]));
    ticks(12);

    // 4: consumer stalled, credits exhausted, then released
    out_ready = 1'b0;
    gsnap = grant_cnt;
    for (int c = 0; c < 20; c++) begin
      all_valid_data(c + 40);
      tick();
    end
    chk("t4_grants_stalled", 64'(grant_cnt - gsnap), 64'(FIFO_DEPTH));
    chk("t4_ready_low", 64'(req_ready), 64'(0));
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      all_valid_data(c + 80);
      tick();
    end
    req_valid = '0;
    ticks(20);
    chk("t4_no_loss", 64'(pop_cnt), 64'(grant_cnt));

    // 5: flush with 5 bytes in flight
    gsnap = grant_cnt;
    for (int c = 0; c < 5; c++) begin
      all_valid_data(c + 120);
      tick();
    end
    chk("t5_issued", 64'(grant_cnt - gsnap), 64'(5));
    flush = 1'b1;
    gsnap = grant_cnt;
    psnap = pop_cnt;
    for (int k = 0; k < 30 && !flush_done; k++) tick();
    chk("t5_flush_done", 64'(flush_done), 64'(1));
    chk("t5_pops_before_done", 64'(pop_cnt - psnap), 64'(5));
    chk("t5_no_grant", 64'(grant_cnt - gsnap), 64'(0));
    ticks(2);
    flush = 1'b0;
    gsnap = grant_cnt;
    ticks(2);
    chk("t5_resume", 64'(grant_cnt - gsnap), 64'(1));
    req_valid = '0;
    ticks(12);

    // 6: reset with pipeline full
    for (int c = 0; c < 4; c++) begin
      all_valid_data(c + 160);
      tick();
    end
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    req_valid = '0;
    osnap = ov_cnt;
    ticks(10);
    chk("t6_no_spurious", 64'(ov_cnt - osnap), 64'(0));
    req_valid = 4'b0010;
    req_data  = 32'h0000_ff00;
    tick();
    req_valid = '0;
    ticks(10);
    chk("t6_hash", last_out_hash, 64'h42c0e488475e05d9);
    chk("t6_id", 64'(last_out_id), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
